// File: rtl/obstacle_scanner.sv
// obstacle_scanner
//   Circular queue of live obstacles feeding the per-frame game logic.
//   The generator pushes words through an in_valid/in_ready handshake while
//   the block is idle. On each new_frame (unless game_over) every stored
//   obstacle is moved SPEED points closer to the player and written back.
//   Head entries that have already passed the player are retired. Surviving
//   entries are streamed one per cycle with a first-row flag.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   new_frame       : one-cycle frame strobe
//   game_over       : suppresses the frame scan while high
//   in_obstacle     : {type[2:0], lane[1:0], depth[10:0]} from the generator
//   in_valid        : in_obstacle is valid
//   in_ready        : queue accepts in_obstacle this cycle
//   obstacle        : streamed word with updated depth
//   obstacle_valid  : obstacle is valid this cycle
//   firstrow        : streamed obstacle is in the player's row
//   scan_done       : one-cycle pulse ending a frame scan
//   count           : number of stored obstacles
//   frame_overrun   : sticky, new_frame arrived while a scan was in progress
//
// Build option
//   OBSTACLE_DROP_EMPTY_EN : when defined, words of type 3'b000 complete the
//                            handshake but are not stored.

module obstacle_scanner #(
    parameter int DEPTH         = 16,
    parameter int SPEED         = 1,
    parameter int FIRST_ROW_MAX = 63,
    parameter int RAMP_ROW_MAX  = 319
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   new_frame,
    input  logic                   game_over,
    input  logic [15:0]            in_obstacle,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [15:0]            obstacle,
    output logic                   obstacle_valid,
    output logic                   firstrow,
    output logic                   scan_done,
    output logic [$clog2(DEPTH):0] count,
    output logic                   frame_overrun
);

    localparam int              AW     = $clog2(DEPTH);
    localparam int              CW     = AW + 1;
    localparam logic [CW-1:0]   CAP    = CW'(DEPTH);
    localparam logic [10:0]     SPD    = 11'(SPEED);
    localparam logic [10:0]     FR_MAX = 11'(FIRST_ROW_MAX);
    localparam logic [10:0]     RR_MAX = 11'(RAMP_ROW_MAX);
    localparam logic [2:0]      T_RAMP = 3'b101;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t        state, state_nx;
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] head, tail, ptr;
    logic [CW-1:0] left;

    logic [15:0]   cur;
    logic [10:0]   d, d_nx;
    logic          retire, row_hit, take, store;

    // Entry under the scan pointer and its advanced depth.
    // ptr stays equal to head only while every entry so far was retired,
    // so (ptr == head) marks the leading run of retire candidates.
    always_comb begin
        cur     = mem[ptr];
        d       = cur[10:0];
        d_nx    = (d >= SPD) ? d - SPD : '0;
        retire  = (left != '0) && (ptr == head) && (d < SPD);
        row_hit = (cur[15:13] == T_RAMP) ? (d_nx <= RR_MAX) : (d_nx <= FR_MAX);
    end

    assign in_ready = (state == IDLE) && !new_frame && (count < CAP);
    assign take     = in_valid && in_ready;

`ifdef OBSTACLE_DROP_EMPTY_EN
    assign store = take && (in_obstacle[15:13] != 3'b000);
`else
    assign store = take;
`endif

    // One extra SCAN cycle after the last entry (left == 0) places scan_done
    // one cycle after the last beat, and at T+2 for an empty queue.
    always_comb begin
        state_nx  = state;
        scan_done = 1'b0;
        case (state)
            IDLE:    if (new_frame && !game_over) state_nx = SCAN;
            SCAN:    if (left == '0) state_nx = DONE;
            DONE: begin
                state_nx  = IDLE;
                scan_done = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Storage has no reset; count/head/tail define which entries are live.
    // Inserts happen only in IDLE and write-backs only in SCAN.
    always_ff @(posedge clk) begin
        if (store)
            mem[tail] <= in_obstacle;
        else if (state == SCAN && left != '0 && !retire)
            mem[ptr] <= {cur[15:11], d_nx};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            ptr            <= '0;
            left           <= '0;
            obstacle       <= '0;
            obstacle_valid <= 1'b0;
            firstrow       <= 1'b0;
            frame_overrun  <= 1'b0;
        end else begin
            state          <= state_nx;
            obstacle_valid <= 1'b0;

            if (new_frame && state != IDLE)
                frame_overrun <= 1'b1;

            if (store) begin
                tail  <= tail + AW'(1);
                count <= count + CW'(1);
            end

            if (state == IDLE && state_nx == SCAN) begin
                ptr  <= head;
                left <= count;
            end

            if (state == SCAN && left != '0) begin
                ptr  <= ptr + AW'(1);
                left <= left - CW'(1);
                if (retire) begin
                    head  <= head + AW'(1);
                    count <= count - CW'(1);
                end else begin
                    obstacle       <= {cur[15:11], d_nx};
                    obstacle_valid <= 1'b1;
                    firstrow       <= row_hit;
                end
            end
        end
    end

endmodule
